// File: rtl/pattern_stream_gen.sv
// pattern_stream_gen: serial word transmitter for sequence detectors,
// with an in-line Mealy reference model of the detector's response.
module pattern_stream_gen #(
    parameter int         WIDTH      = 8,
    parameter logic [7:0] PATTERN    = 8'b0000_1101,
    parameter int         PLEN       = 4,
    parameter int         GAP_CYCLES = 1,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [3:0]       load_reps,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             match_exp,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int            IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [1:0]       state;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] sreg;
    logic [IW-1:0]    bit_idx;
    logic [3:0]       rep_left;
    logic [3:0]       gap_cnt;
    logic [PLEN-2:0]  hist;
    logic [PLEN-1:0]  window;
    logic             final_bit;
    logic             accept;

    // Last bit of the last repetition: the only SHIFT cycle that may accept.
    assign final_bit  = (state == S_SHIFT) && (bit_idx == LAST)
                        && (rep_left <= 4'd1);
    assign load_ready = (state == S_IDLE) || ((GAP_CYCLES == 0) && final_bit);
    assign accept     = load_valid && load_ready;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            word       <= '0;
            sreg       <= '0;
            bit_idx    <= '0;
            rep_left   <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end else if (accept) begin
            state      <= S_SHIFT;
            word       <= load_data;
            sreg       <= {load_data[WIDTH-2:0], 1'b0};
            bit_idx    <= '0;
            rep_left   <= (load_reps == 4'd0) ? 4'd1 : load_reps;
            dout       <= load_data[WIDTH-1];
            dout_valid <= 1'b1;
        end else begin
            unique case (state)
                S_SHIFT: begin
                    if (bit_idx != LAST) begin
                        dout    <= sreg[WIDTH-1];
                        sreg    <= {sreg[WIDTH-2:0], 1'b0};
                        bit_idx <= bit_idx + 1'b1;
                    end else if (rep_left > 4'd1) begin
                        rep_left <= rep_left - 4'd1;
                        dout     <= word[WIDTH-1];
                        sreg     <= {word[WIDTH-2:0], 1'b0};
                        bit_idx  <= '0;
                    end else begin
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= 4'(GAP_CYCLES - 1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) state <= S_IDLE;
                    else gap_cnt <= gap_cnt - 4'd1;
                end
                default: begin
                    state      <= S_IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

    // History shifts every clock, so idle zeros take part in matching.
    assign window    = {hist, dout};
    assign match_exp = (window == PATTERN[PLEN-1:0]);

    always_ff @(posedge clk) begin
        if (rst) hist <= '0;
        else hist <= window[PLEN-2:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            match_cnt <= '0;
        end else if (match_exp && (match_cnt != CMAX)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule
